// File: rtl/multicycle_ctrl_if.sv
// Controller-to-datapath bundle: opcode/mem_ready in, mux selects and enables out.
// The master side is the controller; the slave side is the datapath.
interface multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_we;
    logic               pc_we_cond;
    logic               iord;
    logic               mem_rd;
    logic               mem_wr;
    logic               ir_we;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_we;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_src;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  opcode, mem_ready,
        output pc_we, pc_we_cond, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg,
               reg_we, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_we, pc_we_cond, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg,
               reg_we, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing the shared ALU and memory port.
// Latency with mem_ready high: BEQ/J 3, R/ADDI/SW 4, LW 5 cycles.
// Memory states hold with mem_rd/mem_wr asserted until mem_ready completes the access.
module multicycle_ctrl #(
    parameter int          STATE_W  = 4,
    parameter logic [5:0]  OP_RTYPE = 6'h00,
    parameter logic [5:0]  OP_LW    = 6'h23,
    parameter logic [5:0]  OP_SW    = 6'h2B,
    parameter logic [5:0]  OP_BEQ   = 6'h04,
    parameter logic [5:0]  OP_ADDI  = 6'h08,
    parameter logic [5:0]  OP_J     = 6'h02
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = FETCH;
        bus.pc_we      = 1'b0;
        bus.pc_we_cond = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_we      = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_we     = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.pc_src     = 2'b00;
        bus.illegal_op = 1'b0;
        bus.state_o    = STATE_W'(state_q);

        case (state_q)
            FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.alu_src_b = 2'b01;
                // IR/PC load only on the completing cycle so a stalled fetch advances once
                bus.ir_we     = bus.mem_ready;
                bus.pc_we     = bus.mem_ready;
                state_d       = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = MEMADR;
                else if (bus.opcode == OP_RTYPE)                state_d = EXEC;
                else if (bus.opcode == OP_BEQ)                  state_d = BRANCH;
                else if (bus.opcode == OP_ADDI)                 state_d = ADDIEX;
                else if (bus.opcode == OP_J)                    state_d = JUMP;
                else                                            bus.illegal_op = 1'b1;
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                if (bus.opcode == OP_LW)      state_d = MEMRD;
                else if (bus.opcode == OP_SW) state_d = MEMWR;
            end
            MEMRD: begin
                bus.mem_rd = 1'b1;
                bus.iord   = 1'b1;
                state_d    = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                bus.mem_wr = 1'b1;
                bus.iord   = 1'b1;
                state_d    = bus.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = ALUWB;
            end
            ALUWB: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = 2'b01;
                bus.pc_we_cond = 1'b1;
                bus.pc_src     = 2'b01;
            end
            ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = ADDIWB;
            end
            ADDIWB: begin
                bus.reg_we = 1'b1;
            end
            JUMP: begin
                bus.pc_we  = 1'b1;
                bus.pc_src = 2'b10;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: driver queues expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.STATE_W(4)) bus ();

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // {pc_we,pc_we_cond,iord,mem_rd,mem_wr,ir_we,reg_dst,mem_to_reg,reg_we,
    //  alu_src_a,alu_src_b,alu_op,pc_src,illegal_op}
    logic [16:0] act;
    assign act = {bus.pc_we, bus.pc_we_cond, bus.iord, bus.mem_rd, bus.mem_wr, bus.ir_we,
                  bus.reg_dst, bus.mem_to_reg, bus.reg_we, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_op, bus.pc_src, bus.illegal_op};

    function automatic logic [16:0] pack(input logic pcw, pcc, iord, mrd, mwr, irw, rdst,
                                         m2r, rwe, sa, input logic [1:0] sb, op, psrc,
                                         input logic ill);
        return {pcw, pcc, iord, mrd, mwr, irw, rdst, m2r, rwe, sa, sb, op, psrc, ill};
    endfunction

    // Expected outputs from the state table, written independently of the RTL.
    function automatic logic [16:0] expect_outs(input logic [3:0] st, input logic rdy,
                                                input logic [5:0] op);
        logic ill;
        ill = !(op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
                op == 6'h08 || op == 6'h02);
        case (st)
            4'd0:  return pack(rdy,0,0,1,0,rdy,0,0,0,0,2'b01,2'b00,2'b00,0);
            4'd1:  return pack(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,ill);
            4'd2:  return pack(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
            4'd3:  return pack(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
            4'd4:  return pack(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
            4'd5:  return pack(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
            4'd6:  return pack(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
            4'd7:  return pack(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
            4'd8:  return pack(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
            4'd9:  return pack(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
            4'd10: return pack(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
            4'd11: return pack(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
            default: return '0;
        endcase
    endfunction

    // One cycle: drive inputs, queue what the DUT must show during this cycle.
    task automatic step(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        exp_t e;
        bus.mem_ready = rdy;
        bus.opcode    = op;
        e.st   = st;
        e.outs = expect_outs(st, rdy, op);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] r);
        total++;
        if (a !== r) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, a, r);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("state@%0t", $time), 32'(bus.state_o), 32'(e.st));
            check($sformatf("outs@%0t st=%0d", $time, e.st), 32'(act), 32'(e.outs));
        end
    end

    initial begin
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'h00;
        #3;
        check("reset_state", 32'(bus.state_o), 32'd0);
        check("reset_outs", 32'(act), 32'(pack(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // R-type
        step(0,1,6'h00); step(1,1,6'h00); step(6,1,6'h00); step(7,1,6'h00);
        // LW with 3 wait cycles in MEMRD; opcode changes in MEMRD must be ignored
        step(0,1,6'h23); step(1,1,6'h23); step(2,1,6'h23);
        step(3,0,6'h3F); step(3,0,6'h00); step(3,0,6'h2B); step(3,1,6'h23); step(4,1,6'h23);
        // SW with two stalled FETCH cycles
        step(0,0,6'h2B); step(0,0,6'h2B); step(0,1,6'h2B);
        step(1,1,6'h2B); step(2,1,6'h2B); step(5,0,6'h2B); step(5,1,6'h2B);
        // ADDI
        step(0,1,6'h08); step(1,1,6'h08); step(9,1,6'h08); step(10,1,6'h08);
        // BEQ then J
        step(0,1,6'h04); step(1,1,6'h04); step(8,1,6'h04);
        step(0,1,6'h02); step(1,1,6'h02); step(11,1,6'h02);
        // Illegal opcode, then back to FETCH
        step(0,1,6'h3F); step(1,1,6'h3F);
        step(0,1,6'h00); step(1,1,6'h00);

        // Now in EXEC: async reset with no clock edge
        #2;
        check("pre_reset_exec", 32'(bus.state_o), 32'd6);
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(bus.state_o), 32'd0);
        check("async_mem_rd", 32'(bus.mem_rd), 32'd1);
        check("async_reg_we", 32'(bus.reg_we), 32'd0);
        @(posedge clk); #1;
        check("held_reset_state", 32'(bus.state_o), 32'd0);
        rst_n = 1'b1;

        // Restart from FETCH after the aborted instruction
        step(0,1,6'h00); step(1,1,6'h00); step(6,1,6'h00); step(7,1,6'h00);
        step(0,0,6'h00);

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
